// File: rtl/spi_master.sv
// spi_master: runs one 16-bit mode-0 SPI frame {addr, rw, byte} per start pulse.
// It drives sclk_pin, cs_pin and mosi_pin, and captures the read byte from the
// synchronized miso_pin.
module spi_master #(
  parameter int CLK_DIV = 5,
  parameter int CS_GAP  = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       sclk_pin,
  output logic       cs_pin,
  output logic       mosi_pin,
  input  logic       miso_pin
);

  // One counter serves the SCLK half-period and the CS gap, so it is sized for the larger of the two.
  localparam int CMAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(CS_GAP - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [3:0]    bit_cnt;   // number of SCLK falling edges already produced
  logic [14:0]   tx_sr;     // frame bits still to be driven; frame[15] goes straight to mosi_pin
  logic [7:0]    rx_sr;
  logic          rw_q;
  logic [1:0]    miso_sync;

  // Two-flop synchronizer for the asynchronous miso_pin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) miso_sync <= 2'b00;
    else        miso_sync <= {miso_sync[0], miso_pin};
  end

  // Transaction FSM; every pin and status output is registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_cnt  <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      rw_q     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rdata    <= '0;
      sclk_pin <= 1'b0;
      cs_pin   <= 1'b1;
      mosi_pin <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= SETUP;
            busy     <= 1'b1;
            cs_pin   <= 1'b0;
            sclk_pin <= 1'b0;
            rw_q     <= rw;
            mosi_pin <= addr[6];
            tx_sr    <= {addr[5:0], rw, (rw ? 8'h00 : wdata)};
            cnt      <= '0;
            bit_cnt  <= '0;
          end
        end
        SETUP: begin
          if (cnt == DIV_LAST) begin
            cnt      <= '0;
            sclk_pin <= 1'b1;
            state    <= SHIFT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SHIFT: begin
          if (cnt == DIV_LAST) begin
            cnt      <= '0;
            sclk_pin <= ~sclk_pin;
            if (!sclk_pin) begin
              // Rising edge: the second byte of a read is shifted in on rising edges 9..16.
              if (rw_q && bit_cnt[3]) rx_sr <= {rx_sr[6:0], miso_sync[1]};
            end else if (bit_cnt == 4'd15) begin
              // 16th falling edge: mosi_pin keeps frame[0] through HOLD.
              state <= HOLD;
            end else begin
              bit_cnt  <= bit_cnt + 4'd1;
              mosi_pin <= tx_sr[14];
              tx_sr    <= {tx_sr[13:0], 1'b0};
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HOLD: begin
          if (cnt == DIV_LAST) begin
            cnt      <= '0;
            cs_pin   <= 1'b1;
            mosi_pin <= 1'b0;
            state    <= GAP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            cnt   <= '0;
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            if (rw_q) rdata <= rx_sr;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: randomized and directed transactions with a scoreboard.
// Stimulus pushes the expected frame and rdata; a monitor pops them on each done.
module tb_spi_master;
  localparam int D = 5;
  localparam int G = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       rw = 1'b0;
  logic [6:0] addr = '0;
  logic [7:0] wdata = '0;
  logic       miso_pin = 1'b0;
  logic       busy, done, sclk_pin, cs_pin, mosi_pin;
  logic [7:0] rdata;

  spi_master #(.CLK_DIV(D), .CS_GAP(G)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rw(rw), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .rdata(rdata), .sclk_pin(sclk_pin), .cs_pin(cs_pin),
    .mosi_pin(mosi_pin), .miso_pin(miso_pin)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic [15:0] frame;
    logic [7:0]  rdata;
    bit          b2b;
  } exp_t;

  exp_t       sbq[$];
  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc = 0;
  logic [7:0] slv_byte = '0;
  logic [7:0] model_rdata = '0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
    end
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Bench slave: after falling edge n (8..15) present byte bit 15-n; junk before that.
  int   s_fall = 0;
  logic s_prev = 1'b0;
  initial forever begin
    @(negedge clk);
    if (!rst_n || cs_pin) begin
      s_fall   = 0;
      s_prev   = 1'b0;
      miso_pin = 1'b0;
    end else begin
      if (s_prev && !sclk_pin) begin
        s_fall++;
        if (s_fall >= 8 && s_fall <= 15) miso_pin = slv_byte[15 - s_fall];
        else miso_pin = 1'($urandom_range(0, 1));
      end
      s_prev = sclk_pin;
    end
  end

  // Monitor: captures the frame on sclk rises, tracks edge timing from the cs fall,
  // and checks against the scoreboard on every done pulse.
  logic        cs_p = 1'b1, sclk_p = 1'b0;
  logic [15:0] frame_cap = '0;
  int          fall_cyc = 0, rise_cyc = 0, nrise = 0, nfall = 0, tim_err = 0;
  int          prev_done = -1000, prev_rise = -1000, idle_err = 0;
  exp_t        e;
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      cs_p = 1'b1; sclk_p = 1'b0; nrise = 0; nfall = 0; tim_err = 0; frame_cap = '0;
    end else begin
      if (cs_p && !cs_pin) begin
        fall_cyc = cyc; nrise = 0; nfall = 0; tim_err = 0; frame_cap = '0;
      end
      if (!cs_p && cs_pin) rise_cyc = cyc;
      if (!cs_pin && !sclk_p && sclk_pin) begin
        nrise++;
        frame_cap = {frame_cap[14:0], mosi_pin};
        if (cyc - fall_cyc != (2 * nrise - 1) * D) tim_err++;
      end
      if (!cs_pin && sclk_p && !sclk_pin) begin
        nfall++;
        if (cyc - fall_cyc != 2 * nfall * D) tim_err++;
      end
      if (cs_pin && (sclk_pin || mosi_pin)) idle_err++;
      if (done) begin
        if (sbq.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_done: actual=1 required=0 (cycle %0d)", cyc);
        end else begin
          e = sbq.pop_front();
          chk("frame", 32'(frame_cap), 32'(e.frame));
          chk("rise_count", nrise, 16);
          chk("sclk_timing_errs", tim_err, 0);
          chk("cs_rise_cycle", rise_cyc - fall_cyc, 33 * D);
          chk("done_cycle", cyc - fall_cyc, 33 * D + G);
          chk("busy_at_done", 32'(busy), 0);
          chk("rdata", 32'(rdata), 32'(e.rdata));
          if (e.b2b) begin
            chk("b2b_cs_fall_after_done", fall_cyc - prev_done, 1);
            chk("b2b_cs_high_cycles", fall_cyc - prev_rise, G + 1);
          end
        end
        prev_done = cyc;
        prev_rise = rise_cyc;
      end
      cs_p = cs_pin;
      sclk_p = sclk_pin;
    end
  end

  // Reference model: frame layout and rdata retention from the block's rules.
  task automatic push_exp(input bit r, input logic [6:0] a, input logic [7:0] w,
                          input logic [7:0] sb, input bit b2b);
    exp_t x;
    x.frame = {a, r, (r ? 8'h00 : w)};
    if (r) model_rdata = sb;
    x.rdata = model_rdata;
    x.b2b   = b2b;
    sbq.push_back(x);
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 500 && busy; k++) @(negedge clk);
    if (busy) begin
      n_cmp++; n_err++;
      $display("FAIL idle_timeout: actual=busy required=idle (cycle %0d)", cyc);
    end
  endtask

  task automatic wait_done();
    int k;
    for (k = 0; k < 500; k++) begin
      @(negedge clk);
      if (done) return;
    end
    n_cmp++; n_err++;
    $display("FAIL done_timeout: actual=none required=done (cycle %0d)", cyc);
  endtask

  task automatic drive_req(input bit r, input logic [6:0] a, input logic [7:0] w, input logic [7:0] sb);
    rw = r; addr = a; wdata = w; slv_byte = sb; start = 1'b1;
  endtask

  task automatic run_txn(input bit r, input logic [6:0] a, input logic [7:0] w,
                         input logic [7:0] sb, input bit glitch);
    wait_idle();
    drive_req(r, a, w, sb);
    push_exp(r, a, w, sb, 1'b0);
    @(negedge clk);
    start = 1'b0;
    // Inputs must have been latched: scramble them for the rest of the frame.
    rw = 1'($urandom); addr = 7'($urandom); wdata = 8'($urandom);
    if (glitch) begin
      repeat (39) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    @(negedge clk);
    wait_idle();
  endtask

  initial begin
    logic [7:0] sb;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_outputs", 32'({busy, done, rdata, sclk_pin, cs_pin, mosi_pin}), 32'(13'b0_0_00000000_0_1_0));

    // Directed write then read from the test plan.
    run_txn(1'b0, 7'h55, 8'hA3, 8'($urandom), 1'b0);
    run_txn(1'b1, 7'h55, 8'h00, 8'hA3, 1'b0);

    // Back-to-back with start held high.
    wait_idle();
    drive_req(1'b0, 7'($urandom), 8'($urandom), 8'($urandom));
    push_exp(rw, addr, wdata, slv_byte, 1'b0);
    wait_done();
    drive_req(1'b1, 7'($urandom), 8'($urandom), 8'($urandom));
    push_exp(rw, addr, wdata, slv_byte, 1'b1);
    wait_done();
    start = 1'b0;
    @(negedge clk);

    // Start pulse in the middle of a transaction.
    run_txn(1'($urandom), 7'($urandom), 8'($urandom), 8'($urandom), 1'b1);

    // Load a nonzero rdata, then abort a read at cycle 90.
    sb = 8'($urandom) | 8'h01;
    run_txn(1'b1, 7'($urandom), 8'($urandom), sb, 1'b0);
    wait_idle();
    drive_req(1'b1, 7'($urandom), 8'($urandom), 8'($urandom));
    @(negedge clk);
    start = 1'b0;
    repeat (89) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_outputs", 32'({busy, done, rdata, sclk_pin, cs_pin, mosi_pin}), 32'(13'b0_0_00000000_0_1_0));
    model_rdata = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    chk("abort_no_done_pending", sbq.size(), 0);

    // Normal traffic after the abort, then randomized transactions.
    run_txn(1'b0, 7'($urandom), 8'($urandom), 8'($urandom), 1'b0);
    run_txn(1'b1, 7'($urandom), 8'($urandom), 8'($urandom), 1'b0);
    for (int i = 0; i < 10; i++)
      run_txn(1'($urandom), 7'($urandom), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 3) == 0));

    repeat (400) @(negedge clk);
    chk("scoreboard_empty", sbq.size(), 0);
    chk("idle_pin_errs", idle_err, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
